// File: rtl/nobl_sched_pkg.sv
// Shared slot encoding, pipeline depths and read tag type for the
// two-channel NoBL SRAM FIFO scheduler.
package nobl_sched_pkg;

  typedef enum logic [1:0] {
    SLOT_W0 = 2'd0,
    SLOT_R0 = 2'd1,
    SLOT_W1 = 2'd2,
    SLOT_R1 = 2'd3
  } slot_e;

  localparam int NUM_SLOTS    = 4;
  // Cycles from the address on the pins to the late-write data on the pins.
  localparam int WRITE_COMMIT = 2;
  // Cycles from read grant to read_data_N / data_avail_N.
  localparam int READ_LATENCY = 4;

  typedef struct packed {
    logic vld;
    logic ch;
  } rd_tag_t;

endpackage

// File: rtl/nobl_rr_arb.sv
// 4-way round-robin arbiter: combinational one-hot grant, 0 cycles.
// The pointer moves to the slot after the winner and holds when nothing is granted.
module nobl_rr_arb
  import nobl_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= SLOT_W0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/nobl_fifo_sched.sv
// Two FIFO channels sharing one NoBL SRAM, one op per cycle by round-robin.
// Grant is combinational; write data hits the pins 3 cycles later, read data returns in 4.
module nobl_fifo_sched
  import nobl_sched_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int RAM_DEPTH  = 19,
  parameter int FIFO_DEPTH = RAM_DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      RAM_D_pi,
  output logic [WIDTH-1:0]      RAM_D_po,
  output logic                  RAM_D_poe,
  output logic [RAM_DEPTH-1:0]  RAM_A,
  output logic                  RAM_WEn,
  output logic                  RAM_CENn,
  output logic                  RAM_LDn,
  output logic                  RAM_OEn,
  output logic                  RAM_CE1n,
  input  logic                  write_strobe_0,
  input  logic [WIDTH-1:0]      write_data_0,
  output logic                  space_avail_0,
  input  logic                  write_strobe_1,
  input  logic [WIDTH-1:0]      write_data_1,
  output logic                  space_avail_1,
  input  logic                  read_strobe_0,
  output logic [WIDTH-1:0]      read_data_0,
  output logic                  data_avail_0,
  input  logic                  read_strobe_1,
  output logic [WIDTH-1:0]      read_data_1,
  output logic                  data_avail_1,
  output logic [FIFO_DEPTH:0]   capacity_0,
  output logic [FIFO_DEPTH:0]   capacity_1
);

  localparam int OW = FIFO_DEPTH + 1;
  localparam logic [OW-1:0] OCC_FULL = {1'b1, {FIFO_DEPTH{1'b0}}};

  logic [OW-1:0]          wr_occ_q [2];
  logic [OW-1:0]          wr_occ_d [2];
  logic [OW-1:0]          rd_occ_q [2];
  logic [OW-1:0]          rd_occ_d [2];
  logic [OW-1:0]          cap_q    [2];
  logic [FIFO_DEPTH-1:0]  wptr_q   [2];
  logic [FIFO_DEPTH-1:0]  wptr_d   [2];
  logic [FIFO_DEPTH-1:0]  rptr_q   [2];
  logic [FIFO_DEPTH-1:0]  rptr_d   [2];

  logic [3:0]             req, gnt;
  logic [1:0]             wr_gnt, rd_gnt, commit;
  logic                   gnt_any, gnt_wr, gnt_ch;

  logic [RAM_DEPTH-1:0]   ram_a_q, ram_a_d;
  logic                   ram_wen_q, ram_ce1n_q, ram_poe_q;
  logic [WIDTH-1:0]       ram_dpo_q;

  logic [WRITE_COMMIT-1:0] wvld_q, wch_q;
  logic [WIDTH-1:0]        wdat_q [WRITE_COMMIT];
  rd_tag_t                 tag_q  [READ_LATENCY];
  logic [WIDTH-1:0]        rdat_q [2];

  // Reads are limited by committed writes so an address is never read before its late write lands.
  always_comb begin
    req          = '0;
    req[SLOT_W0] = write_strobe_0 & (wr_occ_q[0] < OCC_FULL) & ~rst;
    req[SLOT_R0] = read_strobe_0  & (rd_occ_q[0] != '0)      & ~rst;
    req[SLOT_W1] = write_strobe_1 & (wr_occ_q[1] < OCC_FULL) & ~rst;
    req[SLOT_R1] = read_strobe_1  & (rd_occ_q[1] != '0)      & ~rst;
  end

  nobl_rr_arb u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign wr_gnt  = {gnt[SLOT_W1], gnt[SLOT_W0]};
  assign rd_gnt  = {gnt[SLOT_R1], gnt[SLOT_R0]};
  assign gnt_any = |gnt;
  assign gnt_wr  = |wr_gnt;
  assign gnt_ch  = gnt[SLOT_W1] | gnt[SLOT_R1];
  assign commit  = {wvld_q[WRITE_COMMIT-1] &  wch_q[WRITE_COMMIT-1],
                    wvld_q[WRITE_COMMIT-1] & ~wch_q[WRITE_COMMIT-1]};

  assign ram_a_d = gnt_any ? {gnt_ch, (gnt_wr ? wptr_q[gnt_ch] : rptr_q[gnt_ch])} : ram_a_q;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      wptr_d[n]   = wptr_q[n] + FIFO_DEPTH'(wr_gnt[n]);
      rptr_d[n]   = rptr_q[n] + FIFO_DEPTH'(rd_gnt[n]);
      wr_occ_d[n] = wr_occ_q[n] + OW'(wr_gnt[n]) - OW'(rd_gnt[n]);
      rd_occ_d[n] = rd_occ_q[n] + OW'(commit[n]) - OW'(rd_gnt[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        wr_occ_q[n] <= '0;
        rd_occ_q[n] <= '0;
        wptr_q[n]   <= '0;
        rptr_q[n]   <= '0;
        cap_q[n]    <= OCC_FULL;
        rdat_q[n]   <= '0;
      end
      for (int i = 0; i < WRITE_COMMIT; i++) wdat_q[i] <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      wvld_q     <= '0;
      wch_q      <= '0;
      ram_a_q    <= '0;
      ram_wen_q  <= 1'b1;
      ram_ce1n_q <= 1'b1;
      ram_poe_q  <= 1'b0;
      ram_dpo_q  <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        wr_occ_q[n] <= wr_occ_d[n];
        rd_occ_q[n] <= rd_occ_d[n];
        wptr_q[n]   <= wptr_d[n];
        rptr_q[n]   <= rptr_d[n];
        cap_q[n]    <= OCC_FULL - wr_occ_d[n];
      end
      wvld_q    <= {wvld_q[WRITE_COMMIT-2:0], gnt_wr};
      wch_q     <= {wch_q[WRITE_COMMIT-2:0], gnt_ch};
      wdat_q[0] <= gnt_ch ? write_data_1 : write_data_0;
      for (int i = 1; i < WRITE_COMMIT; i++) wdat_q[i] <= wdat_q[i-1];
      tag_q[0]  <= {|rd_gnt, gnt_ch};
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (tag_q[READ_LATENCY-2].vld) rdat_q[tag_q[READ_LATENCY-2].ch] <= RAM_D_pi;
      ram_a_q    <= ram_a_d;
      ram_wen_q  <= ~gnt_wr;
      ram_ce1n_q <= ~gnt_any;
      ram_poe_q  <= wvld_q[WRITE_COMMIT-1];
      if (wvld_q[WRITE_COMMIT-1]) ram_dpo_q <= wdat_q[WRITE_COMMIT-1];
    end
  end

  assign space_avail_0 = wr_gnt[0];
  assign space_avail_1 = wr_gnt[1];
  assign data_avail_0  = tag_q[READ_LATENCY-1].vld & ~tag_q[READ_LATENCY-1].ch;
  assign data_avail_1  = tag_q[READ_LATENCY-1].vld &  tag_q[READ_LATENCY-1].ch;
  assign read_data_0   = rdat_q[0];
  assign read_data_1   = rdat_q[1];
  assign capacity_0    = cap_q[0];
  assign capacity_1    = cap_q[1];

  assign RAM_A     = ram_a_q;
  assign RAM_WEn   = ram_wen_q;
  assign RAM_CE1n  = ram_ce1n_q;
  assign RAM_D_poe = ram_poe_q;
  assign RAM_D_po  = ram_dpo_q;
  assign RAM_CENn  = 1'b0;
  assign RAM_LDn   = 1'b0;
  assign RAM_OEn   = 1'b0;

endmodule

// File: tb/tb_nobl_fifo_sched.sv
// Bench for nobl_fifo_sched: NoBL SRAM model on the pins, per-channel data queues as reference.
// A reduced RAM_DEPTH keeps the channel-full boundary reachable in a short run.
module tb_nobl_fifo_sched;

  localparam int WIDTH = 18;
  localparam int RD    = 8;
  localparam int FD    = RD - 1;
  localparam int DEPTH = 1 << FD;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  RAM_D_pi = '0;
  logic [WIDTH-1:0]  RAM_D_po;
  logic              RAM_D_poe;
  logic [RD-1:0]     RAM_A;
  logic              RAM_WEn, RAM_CENn, RAM_LDn, RAM_OEn, RAM_CE1n;
  logic              write_strobe_0, write_strobe_1, read_strobe_0, read_strobe_1;
  logic [WIDTH-1:0]  write_data_0, write_data_1;
  logic              space_avail_0, space_avail_1, data_avail_0, data_avail_1;
  logic [WIDTH-1:0]  read_data_0, read_data_1;
  logic [FD:0]       capacity_0, capacity_1;

  always #5 clk = ~clk;

  nobl_fifo_sched #(.WIDTH(WIDTH), .RAM_DEPTH(RD), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .rst            (rst),
    .RAM_D_pi       (RAM_D_pi),
    .RAM_D_po       (RAM_D_po),
    .RAM_D_poe      (RAM_D_poe),
    .RAM_A          (RAM_A),
    .RAM_WEn        (RAM_WEn),
    .RAM_CENn       (RAM_CENn),
    .RAM_LDn        (RAM_LDn),
    .RAM_OEn        (RAM_OEn),
    .RAM_CE1n       (RAM_CE1n),
    .write_strobe_0 (write_strobe_0),
    .write_data_0   (write_data_0),
    .space_avail_0  (space_avail_0),
    .write_strobe_1 (write_strobe_1),
    .write_data_1   (write_data_1),
    .space_avail_1  (space_avail_1),
    .read_strobe_0  (read_strobe_0),
    .read_data_0    (read_data_0),
    .data_avail_0   (data_avail_0),
    .read_strobe_1  (read_strobe_1),
    .read_data_1    (read_data_1),
    .data_avail_1   (data_avail_1),
    .capacity_0     (capacity_0),
    .capacity_1     (capacity_1)
  );

  // NoBL SRAM: address in cycle k, write data taken / read data driven in cycle k+2.
  logic [WIDTH-1:0] mem [0:(1<<RD)-1];
  logic             s1_vld = 1'b0, s1_we = 1'b0, s2_vld = 1'b0, s2_we = 1'b0;
  logic [RD-1:0]    s1_a = '0, s2_a = '0;

  always @(posedge clk) begin
    s1_vld <= ~RAM_CE1n;
    s1_we  <= ~RAM_WEn;
    s1_a   <= RAM_A;
    s2_vld <= s1_vld;
    s2_we  <= s1_we;
    s2_a   <= s1_a;
    RAM_D_pi <= (s1_vld && !s1_we) ? mem[s1_a] : WIDTH'($urandom);
    if (s2_vld && s2_we && RAM_D_poe) mem[s2_a] <= RAM_D_po;
  end

  int checks = 0;
  int errors = 0;

  // Reference state: per-channel counts and FIFO contents, plus per-cycle grant history.
  int               c, rr;
  int               nw [2];
  int               nr [2];
  int               cw [2];
  int               wpend [2][$];
  logic [WIDTH-1:0] dq [2][$];
  int               hslot [int];
  int               haddr [int];
  logic [WIDTH-1:0] hdat  [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  function automatic int slot_at(int k);
    if (k < 0 || !hslot.exists(k)) return -1;
    return hslot[k];
  endfunction

  task automatic model_reset();
    c  = 0;
    rr = 0;
    for (int k = 0; k < 2; k++) begin
      nw[k] = 0;
      nr[k] = 0;
      cw[k] = 0;
      wpend[k].delete();
      dq[k].delete();
    end
    hslot.delete();
    haddr.delete();
    hdat.delete();
  endtask

  task automatic model_cycle();
    bit               el [4];
    bit               ws [2];
    bit               rs [2];
    logic [WIDTH-1:0] wd [2];
    int               g, s, n;
    ws[0] = write_strobe_0; ws[1] = write_strobe_1;
    rs[0] = read_strobe_0;  rs[1] = read_strobe_1;
    wd[0] = write_data_0;   wd[1] = write_data_1;
    // A write becomes readable from the third cycle after its grant.
    for (int k = 0; k < 2; k++)
      while (wpend[k].size() > 0 && wpend[k][0] <= c - 3) begin
        void'(wpend[k].pop_front());
        cw[k]++;
      end
    for (int k = 0; k < 2; k++) begin
      el[2*k]   = ws[k] && !rst && (nw[k] - nr[k] < DEPTH);
      el[2*k+1] = rs[k] && !rst && (cw[k] - nr[k] > 0);
    end
    g = -1;
    for (int k = 0; k < 4; k++) begin
      s = (rr + k) % 4;
      if (g < 0 && el[s]) g = s;
    end

    chk("space_avail_0", space_avail_0, g == 0);
    chk("space_avail_1", space_avail_1, g == 2);
    chk("capacity_0", capacity_0, DEPTH - (nw[0] - nr[0]));
    chk("capacity_1", capacity_1, DEPTH - (nw[1] - nr[1]));
    s = slot_at(c - 1);
    chk("RAM_CE1n", RAM_CE1n, s < 0);
    chk("RAM_WEn", RAM_WEn, !(s == 0 || s == 2));
    if (s >= 0) chk("RAM_A", RAM_A, haddr[c-1]);
    s = slot_at(c - 3);
    chk("RAM_D_poe", RAM_D_poe, s == 0 || s == 2);
    if (s == 0 || s == 2) chk("RAM_D_po", RAM_D_po, hdat[c-3]);
    s = slot_at(c - 4);
    chk("data_avail_0", data_avail_0, s == 1);
    chk("data_avail_1", data_avail_1, s == 3);
    if (s == 1) chk("read_data_0", read_data_0, hdat[c-4]);
    if (s == 3) chk("read_data_1", read_data_1, hdat[c-4]);

    hslot[c] = g;
    if (g >= 0) begin
      rr = (g + 1) % 4;
      n  = g / 2;
      if (g % 2 == 0) begin
        haddr[c] = n * DEPTH + nw[n] % DEPTH;
        hdat[c]  = wd[n];
        dq[n].push_back(wd[n]);
        wpend[n].push_back(c);
        nw[n]++;
      end else begin
        haddr[c] = n * DEPTH + nr[n] % DEPTH;
        hdat[c]  = dq[n].pop_front();
        nr[n]++;
      end
    end
    hslot.delete(c - 6);
    haddr.delete(c - 6);
    hdat.delete(c - 6);
    c++;
    if (rst) model_reset();
  endtask

  task automatic step(input bit w0, input bit r0, input bit w1, input bit r1, input bit do_rst);
    @(posedge clk);
    #1;
    rst            = do_rst;
    write_strobe_0 = w0;
    read_strobe_0  = r0;
    write_strobe_1 = w1;
    read_strobe_1  = r1;
    write_data_0   = WIDTH'($urandom);
    write_data_1   = WIDTH'($urandom);
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    rst = 1'b1;
    write_strobe_0 = 1'b0; write_strobe_1 = 1'b0;
    read_strobe_0  = 1'b0; read_strobe_1  = 1'b0;
    write_data_0   = '0;   write_data_1   = '0;
    model_reset();

    repeat (3) step(0, 0, 0, 0, 1);
    chk("rst_RAM_A", RAM_A, 0);
    chk("rst_RAM_D_po", RAM_D_po, 0);
    chk("rst_RAM_D_poe", RAM_D_poe, 0);
    chk("rst_RAM_CENn", RAM_CENn, 0);
    chk("rst_RAM_LDn", RAM_LDn, 0);
    chk("rst_RAM_OEn", RAM_OEn, 0);
    chk("rst_read_data_0", read_data_0, 0);
    chk("rst_read_data_1", read_data_1, 0);
    chk("rst_capacity_0", capacity_0, DEPTH);
    repeat (6) step(0, 0, 0, 0, 0);

    // Eight writes on channel 0, then read them back.
    repeat (8) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("cap0_after_8_writes", capacity_0, DEPTH - 8);
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (14) step(0, 1, 0, 0, 0);

    // All four requesters active.
    repeat (48) step(1, 1, 1, 1, 0);

    // Fill channel 1, then one read frees exactly one write slot.
    for (int i = 0; i < 3 * DEPTH && (nw[1] - nr[1] < DEPTH); i++) step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    chk("cap1_full", capacity_1, 0);
    step(0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    chk("cap1_refull", capacity_1, 0);

    // Drain, then reset with three reads in flight.
    repeat (2 * DEPTH + 20) step(0, 1, 0, 1, 0);
    repeat (5) step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("post_rst_data_avail_0", data_avail_0, 0);
    chk("post_rst_data_avail_1", data_avail_1, 0);
    chk("post_rst_RAM_D_poe", RAM_D_poe, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_wptr_addr", RAM_A, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 199) == 0);
    for (int i = 0; i < 200; i++)
      step(1'b0, $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 3) != 0, 1'b0);
    repeat (6) step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
